lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store unit sitting directly upstream of the data memory. Sole driver of the memory's word address, write data, function and enable inputs.
- Accepts byte/half/word load and store requests from the execute stage via valid/ready.
- Checks alignment and sign/zero-extends load data.
- Implements sub-word stores as read-modify-write, because the memory only supports full-word writes.

Parameters:
- ADDR_W, 12, request byte-address width; memory word address = req_addr[ADDR_W-1:2] (10 bits at default).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address, little-endian.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response held until accepted.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned address or illegal size.
- mem_addr  out  ADDR_W-2  word address to memory.
- mem_wr_data  out  32  write word.
- mem_func  out  2  0 read, 1 write.
- mem_en  out  1  memory access enable.
- mem_rd_data  in  32  combinational read data from memory (same cycle).

Behaviour:
- Reset: async, active-low. Clock is clk; reset is reset_n, asynchronous active-low. State goes to IDLE. resp_valid=0, resp_data=0, resp_err=0, mem_en=0, mem_func=0, mem_addr=0, mem_wr_data=0, all request registers cleared.
- Memory outputs are decoded from the state and request registers. Reset asserted mid-operation deasserts mem_en in the same instant, so no partial write occurs.
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready=1. On req_valid, register wr/size/unsigned/addr/wdata, then:
  - error (size==3, half with addr[0]=1, or word with addr[1:0]!=0) -> RESP with err=1. No memory access.
  - load -> RD.
  - word store -> WR.
  - byte/half store -> RD.
- RD: mem_en=1, mem_func=0, mem_addr=word index. Capture mem_rd_data.
  - load -> extract the lane (byte lane addr[1:0], half lane addr[1]), extend per req_unsigned, load into resp_data, go to RESP.
  - store -> save the merged word, go to WR. Merge replaces the selected byte or half lane with req_wdata[7:0] or req_wdata[15:0]; other lanes keep the read value.
- WR: mem_en=1, mem_func=1. mem_wr_data = req_wdata for word stores, merged word for sub-word stores. Go to RESP with resp_data=0.
- RESP: resp_valid=1. resp_data and resp_err stable until resp_valid&resp_ready, then IDLE. Any req_valid in this state is ignored (req_ready=0).
- Latency from accept cycle N:
  - load or word store: resp_valid at N+2.
  - sub-word store: resp_valid at N+3.
  - error: resp_valid at N+1.
- Single outstanding transaction; a new request is accepted no earlier than the cycle after the response handshake.
- mem_func values 2 and 3 are never driven.
- mem_en=0 in IDLE and RESP.

Optional Feature:
- LSU_PERF_CNT_EN defined: adds outputs load_cnt[15:0], store_cnt[15:0] and err_cnt[15:0].
  - Each counter is saturating at 0xFFFF.
  - Each increments by one at the response handshake of the matching completed transaction; errored requests count only in err_cnt.
  - Counters reset to 0.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Memory word 4 (byte 0x010) = 0x8899AABB. Load byte signed at 0x011 -> resp_data=0xFFFFFFAA, resp_err=0, resp_valid exactly 2 cycles after accept, one mem_en cycle with mem_func=0 and mem_addr=4.
- Same word. Load byte unsigned at 0x011 -> 0x000000AA. Load half signed at 0x012 -> 0xFFFF8899. Load word at 0x010 -> 0x8899AABB.
- Store byte 0x5A at 0x013 -> mem_en for exactly 2 cycles (func 0 then func 1), mem_wr_data=0x5A99AABB. A following word load at 0x010 returns 0x5A99AABB.
- Store word at 0x012; also any request with size=3 -> resp_err=1, resp_data=0, resp_valid 1 cycle after accept, mem_en never asserted, memory unchanged.
- resp_ready held low 3 cycles after resp_valid -> resp_valid, resp_data and resp_err stable; req_ready=0; a pending request is accepted only the cycle after the handshake.
- reset_n pulsed low while in WR for a store of 0x11223344 to 0x020 -> mem_en drops immediately, word at 0x020 unchanged. After release: req_ready=1, resp_valid=0; with LSU_PERF_CNT_EN, all counters read 0.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit in front of a word-only data memory: alignment checks, load extension, RMW sub-word stores.
// Optional LSU_PERF_CNT_EN adds saturating load/store/error counters.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic              resp_err,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wr_data,
    output logic [1:0]        mem_func,
    output logic              mem_en,
    input  logic [31:0]       mem_rd_data
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [15:0]       load_cnt,
    output logic [15:0]       store_cnt,
    output logic [15:0]       err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t             state_reg, state_next;
    logic               wr_reg;
    logic [1:0]         size_reg;
    logic               uns_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [31:0]        wdata_reg;
    logic [31:0]        merged_reg;
    logic [31:0]        resp_data_reg;
    logic               resp_err_reg;

    logic               req_err;
    logic               accept;
    logic               done;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        load_ext;
    logic [31:0]        merged_word;

    assign req_err = (req_size == 2'd3) ||
                     (req_size == 2'd1 && req_addr[0]) ||
                     (req_size == 2'd2 && req_addr[1:0] != 2'd0);
    assign accept  = (state_reg == IDLE) && req_valid;
    assign done    = (state_reg == RESP) && resp_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)                             state_next = RESP;
                    else if (!req_wr || req_size != 2'd2)    state_next = RD;
                    else                                     state_next = WR;
                end
            end
            RD:      state_next = wr_reg ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory strobes decode straight from the state so an async reset kills mem_en at once.
    always_comb begin
        req_ready  = (state_reg == IDLE);
        resp_valid = (state_reg == RESP);
        mem_en     = (state_reg == RD) || (state_reg == WR);
        mem_func   = {1'b0, state_reg == WR};
    end

    assign mem_addr    = addr_reg[ADDR_W-1:2];
    assign mem_wr_data = (size_reg == 2'd2) ? wdata_reg : merged_reg;
    assign resp_data   = resp_data_reg;
    assign resp_err    = resp_err_reg;

    always_comb begin
        case (addr_reg[1:0])
            2'd0:    rd_byte = mem_rd_data[7:0];
            2'd1:    rd_byte = mem_rd_data[15:8];
            2'd2:    rd_byte = mem_rd_data[23:16];
            default: rd_byte = mem_rd_data[31:24];
        endcase
        rd_half = addr_reg[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
        case (size_reg)
            2'd0:    load_ext = {{24{~uns_reg & rd_byte[7]}}, rd_byte};
            2'd1:    load_ext = {{16{~uns_reg & rd_half[15]}}, rd_half};
            default: load_ext = mem_rd_data;
        endcase
    end

    // Byte stores always take wdata[7:0]; half stores map wdata[15:0] onto the two lanes of the half.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic lane_sel;
            assign lane_sel = (size_reg == 2'd0) ? (addr_reg[1:0] == 2'(gi))
                                                 : (addr_reg[1] == 1'(gi / 2));
            assign merged_word[gi*8 +: 8] =
                !lane_sel          ? mem_rd_data[gi*8 +: 8] :
                (size_reg == 2'd0) ? wdata_reg[7:0]         :
                                     wdata_reg[(gi % 2)*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_reg        <= 1'b0;
            size_reg      <= 2'd0;
            uns_reg       <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= 32'd0;
            merged_reg    <= 32'd0;
            resp_data_reg <= 32'd0;
            resp_err_reg  <= 1'b0;
        end else begin
            if (accept) begin
                wr_reg        <= req_wr;
                size_reg      <= req_size;
                uns_reg       <= req_unsigned;
                addr_reg      <= req_addr;
                wdata_reg     <= req_wdata;
                resp_data_reg <= 32'd0;
                resp_err_reg  <= req_err;
            end
            if (state_reg == RD) begin
                if (wr_reg) merged_reg    <= merged_word;
                else        resp_data_reg <= load_ext;
            end
        end
    end

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_cnt  <= 16'd0;
            store_cnt <= 16'd0;
            err_cnt   <= 16'd0;
        end else if (done) begin
            if (resp_err_reg) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end else if (wr_reg) begin
                if (store_cnt != 16'hFFFF) store_cnt <= store_cnt + 16'd1;
            end else begin
                if (load_cnt != 16'hFFFF) load_cnt <= load_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a small word memory model; define LSU_PERF_CNT_EN to also check the counters.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wr_data;
    logic [1:0]  mem_func;
    logic        mem_en;
    logic [31:0] mem_rd_data;
`ifdef LSU_PERF_CNT_EN
    logic [15:0] load_cnt, store_cnt, err_cnt;
    int          exp_ld = 0, exp_st = 0, exp_er = 0;
`endif

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ADDR_W(12)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_func(mem_func), .mem_en(mem_en),
        .mem_rd_data(mem_rd_data)
`ifdef LSU_PERF_CNT_EN
        , .load_cnt(load_cnt), .store_cnt(store_cnt), .err_cnt(err_cnt)
`endif
    );

    // Word memory: combinational read, write on the rising edge when enabled with func 1.
    logic [31:0] mem [0:1023];
    logic        preload;
    always @(posedge clk) begin
        if (preload) begin
            mem[4] <= 32'h8899AABB;
            mem[8] <= 32'hCAFEF00D;
        end else if (mem_en && mem_func == 2'd1) begin
            mem[mem_addr] <= mem_wr_data;
        end
    end
    assign mem_rd_data = mem[mem_addr];

    int          total = 0;
    int          bad = 0;
    int          lat;
    int          en_cycles;
    logic [1:0]  func0, func1;
    logic [9:0]  addr_seen;
    logic [31:0] wdata_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [11:0] addr, input logic [31:0] wdata);
        req_wr = wr; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    endtask

    // Called in the cycle after the accept edge; counts cycles up to resp_valid.
    task automatic collect();
        lat = 1; en_cycles = 0; func0 = 2'd0; func1 = 2'd0;
        addr_seen = '0; wdata_seen = 32'd0;
        while (!resp_valid && lat < 10) begin
            if (mem_en) begin
                if (en_cycles == 0) func0 = mem_func;
                else                func1 = mem_func;
                addr_seen = mem_addr;
                if (mem_func == 2'd1) wdata_seen = mem_wr_data;
                en_cycles++;
            end
            tick();
            lat++;
        end
    endtask

    task automatic handshake(input logic wr, input logic err);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
`ifdef LSU_PERF_CNT_EN
        if (err)     exp_er++;
        else if (wr) exp_st++;
        else         exp_ld++;
`endif
    endtask

    task automatic xact(input string name, input logic wr, input logic [1:0] size, input logic uns,
                        input logic [11:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_data, input logic exp_err,
                        input int exp_en);
        issue(wr, size, uns, addr, wdata);
        check({name, " req_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        collect();
        check({name, " latency"}, lat, exp_lat);
        check({name, " resp_data"}, resp_data, exp_data);
        check({name, " resp_err"}, 32'(resp_err), 32'(exp_err));
        check({name, " mem_en cycles"}, en_cycles, exp_en);
        $display("txn %s addr=%h data=%h err=%0d lat=%0d", name, addr, resp_data, resp_err, lat);
        handshake(wr, exp_err);
        check({name, " resp_valid after hs"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; preload = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = 32'd0; resp_ready = 1'b0;
        tick(); tick(); tick();
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_data", resp_data, 32'd0);
        check("rst resp_err", 32'(resp_err), 32'd0);
        check("rst mem_en", 32'(mem_en), 32'd0);
        check("rst mem_func", 32'(mem_func), 32'd0);
        check("rst mem_addr", 32'(mem_addr), 32'd0);
        check("rst mem_wr_data", mem_wr_data, 32'd0);
        preload = 1'b0; reset_n = 1'b1;
        tick();

        xact("lb 011", 1'b0, 2'd0, 1'b0, 12'h011, 32'd0, 2, 32'hFFFFFFAA, 1'b0, 1);
        check("lb 011 func", 32'(func0), 32'd0);
        check("lb 011 addr", 32'(addr_seen), 32'd4);
        xact("lbu 011", 1'b0, 2'd0, 1'b1, 12'h011, 32'd0, 2, 32'h000000AA, 1'b0, 1);
        xact("lh 012", 1'b0, 2'd1, 1'b0, 12'h012, 32'd0, 2, 32'hFFFF8899, 1'b0, 1);
        xact("lw 010", 1'b0, 2'd2, 1'b0, 12'h010, 32'd0, 2, 32'h8899AABB, 1'b0, 1);

        xact("sb 013", 1'b1, 2'd0, 1'b0, 12'h013, 32'h0000005A, 3, 32'd0, 1'b0, 2);
        check("sb 013 func0", 32'(func0), 32'd0);
        check("sb 013 func1", 32'(func1), 32'd1);
        check("sb 013 wr_data", wdata_seen, 32'h5A99AABB);
        check("sb 013 mem", mem[4], 32'h5A99AABB);
        xact("lw after sb", 1'b0, 2'd2, 1'b0, 12'h010, 32'd0, 2, 32'h5A99AABB, 1'b0, 1);

        xact("sw 012 misaligned", 1'b1, 2'd2, 1'b0, 12'h012, 32'hDEADBEEF, 1, 32'd0, 1'b1, 0);
        xact("size3", 1'b0, 2'd3, 1'b0, 12'h010, 32'd0, 1, 32'd0, 1'b1, 0);
        xact("lh 011 misaligned", 1'b0, 2'd1, 1'b0, 12'h011, 32'd0, 1, 32'd0, 1'b1, 0);
        check("mem after errors", mem[4], 32'h5A99AABB);

        xact("sh 012", 1'b1, 2'd1, 1'b0, 12'h012, 32'h1234BEEF, 3, 32'd0, 1'b0, 2);
        check("sh 012 wr_data", wdata_seen, 32'hBEEFAABB);
        xact("lhu 012", 1'b0, 2'd1, 1'b1, 12'h012, 32'd0, 2, 32'h0000BEEF, 1'b0, 1);
        xact("lb 010", 1'b0, 2'd0, 1'b0, 12'h010, 32'd0, 2, 32'hFFFFFFBB, 1'b0, 1);
        xact("lh 010", 1'b0, 2'd1, 1'b0, 12'h010, 32'd0, 2, 32'hFFFFAABB, 1'b0, 1);
        xact("sb 010", 1'b1, 2'd0, 1'b0, 12'h010, 32'hABCDEF77, 3, 32'd0, 1'b0, 2);
        check("sb 010 mem", mem[4], 32'hBEEFAA77);
        xact("sw 010", 1'b1, 2'd2, 1'b0, 12'h010, 32'h12345678, 2, 32'd0, 1'b0, 1);
        check("sw 010 func", 32'(func0), 32'd1);
        check("sw 010 wr_data", wdata_seen, 32'h12345678);
        check("sw 010 mem", mem[4], 32'h12345678);

        // Response back-pressure with a second request waiting.
        issue(1'b0, 2'd2, 1'b0, 12'h010, 32'd0);
        tick();
        req_valid = 1'b0;
        collect();
        check("bp latency", lat, 2);
        issue(1'b0, 2'd0, 1'b1, 12'h013, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("bp resp_valid held", 32'(resp_valid), 32'd1);
            check("bp resp_data held", resp_data, 32'h12345678);
            check("bp resp_err held", 32'(resp_err), 32'd0);
            check("bp req_ready low", 32'(req_ready), 32'd0);
            if (i < 3) tick();
        end
        $display("txn bp lw addr=010 data=%h held 3 cycles", resp_data);
        handshake(1'b0, 1'b0);
        check("bp idle resp_valid", 32'(resp_valid), 32'd0);
        check("bp idle req_ready", 32'(req_ready), 32'd1);
        check("bp idle mem_en", 32'(mem_en), 32'd0);
        tick();
        req_valid = 1'b0;
        check("bp pending accepted", 32'(mem_en), 32'd1);
        collect();
        check("bp lbu latency", lat, 2);
        check("bp lbu data", resp_data, 32'h00000012);
        $display("txn bp lbu addr=013 data=%h", resp_data);
        handshake(1'b0, 1'b0);

`ifdef LSU_PERF_CNT_EN
        check("cnt load", 32'(load_cnt), exp_ld);
        check("cnt store", 32'(store_cnt), exp_st);
        check("cnt err", 32'(err_cnt), exp_er);
`endif

        // Reset during the write cycle of a word store.
        issue(1'b1, 2'd2, 1'b0, 12'h020, 32'h11223344);
        tick();
        req_valid = 1'b0;
        check("rstwr in WR mem_en", 32'(mem_en), 32'd1);
        check("rstwr in WR mem_func", 32'(mem_func), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("rstwr mem_en drops", 32'(mem_en), 32'd0);
        check("rstwr mem_func", 32'(mem_func), 32'd0);
        tick();
        check("rstwr mem unchanged", mem[8], 32'hCAFEF00D);
        reset_n = 1'b1;
        tick();
        check("rstwr req_ready", 32'(req_ready), 32'd1);
        check("rstwr resp_valid", 32'(resp_valid), 32'd0);
        check("rstwr mem still unchanged", mem[8], 32'hCAFEF00D);
        $display("txn reset during sw addr=020 mem=%h", mem[8]);
`ifdef LSU_PERF_CNT_EN
        check("rstwr cnt load", 32'(load_cnt), 32'd0);
        check("rstwr cnt store", 32'(store_cnt), 32'd0);
        check("rstwr cnt err", 32'(err_cnt), 32'd0);
        exp_ld = 0; exp_st = 0; exp_er = 0;
`endif
        xact("lw 020 after rst", 1'b0, 2'd2, 1'b0, 12'h020, 32'd0, 2, 32'hCAFEF00D, 1'b0, 1);
`ifdef LSU_PERF_CNT_EN
        check("cnt load after rst", 32'(load_cnt), exp_ld);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
